// File: rtl/act_readout_seq_pkg.sv
// Shared field layout, bus widths and sequencer state encoding for the
// activation read-out sequencer.
package act_readout_seq_pkg;

  localparam int ADDR_BUS_W   = 16;
  localparam int RDATA_BUS_W  = 32;

  localparam int PE_LSB       = 10;
  localparam int PE_W         = 6;
  localparam int ACT_ADDR_LSB = 0;
  localparam int ACT_ADDR_W   = 6;

  localparam int RD_IDX_LSB   = 16;
  localparam int IDX_W        = 12;
  localparam int RD_ACT_LSB   = 0;
  localparam int ACT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  function automatic logic [ADDR_BUS_W-1:0] make_addr(input logic [PE_W-1:0]       pe,
                                                      input logic [ACT_ADDR_W-1:0] act);
    logic [ADDR_BUS_W-1:0] a;
    a = '0;
    a[PE_LSB +: PE_W]             = pe;
    a[ACT_ADDR_LSB +: ACT_ADDR_W] = act;
    return a;
  endfunction

endpackage

// File: rtl/act_readout_seq_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on o_data
// whenever o_empty is low.
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  // A full FIFO may still accept a word in the same cycle its head leaves.
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/act_readout_seq.sv
// Self-timed sweep of the accelerator's output activations in PE-major order,
// returning (index, activation) pairs on a ready/valid stream.
module act_readout_seq
  import act_readout_seq_pkg::*;
#(
  parameter int ADDR_W     = ADDR_BUS_W,
  parameter int RDATA_W    = RDATA_BUS_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               interrupt,
  input  logic [11:0]        act_no,
  output logic               busy,
  output logic               done,
  output logic               read_en,
  input  logic               read_rdy,
  output logic [ADDR_W-1:0]  read_addr,
  output logic               read_data_rdy,
  input  logic               read_data_vld,
  input  logic [RDATA_W-1:0] read_data,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [11:0]        out_idx,
  output logic [15:0]        out_act
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = IDX_W + ACT_W;

  state_t                r_state;
  logic                  r_int_d;
  logic                  r_start;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_read_en;
  logic [11:0]           r_act_no;
  logic [11:0]           r_issued;
  logic [11:0]           r_received;
  logic [PE_W-1:0]       r_pe;
  logic [ACT_ADDR_W-1:0] r_act;

  logic [FW-1:0]    w_fifo_din;
  logic [FW-1:0]    w_fifo_dout;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_pop;
  logic             w_push;
  logic             w_collect;
  logic             w_req_xfer;
  logic [11:0]      w_issued_n;
  logic [11:0]      w_received_n;
  logic [12:0]      w_used;
  logic             w_credit_ok;
  logic             w_more;
  logic             w_unused_rd;

  assign w_fifo_din   = {read_data[RD_IDX_LSB +: IDX_W], read_data[RD_ACT_LSB +: ACT_W]};
  assign w_unused_rd  = ^read_data[RDATA_W-1:RD_IDX_LSB+IDX_W];
  assign w_collect    = (r_state == ST_ISSUE) | (r_state == ST_DRAIN);
  assign w_push       = read_data_vld & read_data_rdy & w_collect;
  assign w_pop        = ~w_empty & out_rdy;
  assign w_req_xfer   = r_read_en & read_rdy;
  assign w_issued_n   = r_issued + 12'(w_req_xfer);
  assign w_received_n = r_received + 12'(w_push);
  // Slots already spoken for: entries held plus requests whose data has not
  // returned. Uses the registered count, so a pop this cycle is not credited yet.
  assign w_used       = 13'(w_count) + {1'b0, w_issued_n} - {1'b0, r_received};
  assign w_credit_ok  = w_used < 13'(FIFO_DEPTH);
  assign w_more       = w_issued_n != r_act_no;

  assign busy          = r_busy;
  assign done          = r_done;
  assign read_en       = r_read_en;
  assign read_addr     = ADDR_W'(make_addr(r_pe, r_act));
  assign read_data_rdy = (r_state == ST_IDLE) | ~w_full;
  assign out_vld       = ~w_empty;
  assign out_idx       = w_fifo_dout[ACT_W +: IDX_W];
  assign out_act       = w_fifo_dout[ACT_W-1:0];

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_data  (w_fifo_din),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_int_d    <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_read_en  <= 1'b0;
      r_act_no   <= '0;
      r_issued   <= '0;
      r_received <= '0;
      r_pe       <= '0;
      r_act      <= '0;
    end else begin
      r_int_d <= interrupt;
      r_start <= interrupt & ~r_int_d & ~r_busy;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_start) begin
            r_act_no   <= act_no;
            r_issued   <= '0;
            r_received <= '0;
            r_pe       <= '0;
            r_act      <= '0;
            r_busy     <= 1'b1;
            if (act_no == '0) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state   <= ST_ISSUE;
              r_read_en <= w_count < CNT_W'(FIFO_DEPTH);
            end
          end
        end
        ST_ISSUE, ST_DRAIN: begin
          r_issued   <= w_issued_n;
          r_received <= w_received_n;
          if (w_req_xfer) begin
            r_pe <= r_pe + PE_W'(1);
            if (r_pe == '1) r_act <= r_act + ACT_ADDR_W'(1);
          end
          // A raised request stays put until the accelerator takes it.
          if (!(r_read_en && !read_rdy)) r_read_en <= w_more & w_credit_ok;
          if (!w_more && (w_received_n == r_act_no)) begin
            r_state <= ST_FIN;
            r_done  <= 1'b1;
          end else if (!w_more) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_readout_seq.sv
// Randomised bench for act_readout_seq with an accelerator responder and a
// transaction-level reference model of the sweep.
module tb_act_readout_seq;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt;
  logic [11:0] act_no;
  logic        busy, done, read_en, read_rdy;
  logic [15:0] read_addr;
  logic        read_data_rdy, read_data_vld;
  logic [31:0] read_data;
  logic        out_vld, out_rdy;
  logic [11:0] out_idx;
  logic [15:0] out_act;

  always #5 clk = ~clk;

  act_readout_seq #(.ADDR_W(16), .RDATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .act_no(act_no),
    .busy(busy), .done(done), .read_en(read_en), .read_rdy(read_rdy),
    .read_addr(read_addr), .read_data_rdy(read_data_rdy),
    .read_data_vld(read_data_vld), .read_data(read_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_idx(out_idx), .out_act(out_act)
  );

  typedef struct {
    int          due;
    logic [31:0] word;
  } rsp_t;

  rsp_t        pend_q[$];
  logic [27:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, act_no_m = 0, n_req = 0, n_recv = 0, occ = 0;
  int exp_done_cyc = -1, done_cnt = 0, rdy_mode = 0, ordy_mode = 1;
  bit sweep_on = 0, start_empty = 0, force_min = 0, prev_en = 0, prev_rdy = 0, int_level = 0;
  logic [15:0] prev_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // PE-major walk: 64 PEs per activation slot.
  function automatic logic [15:0] exp_addr(input int k);
    int pe, a;
    pe = k % 64;
    a  = k / 64;
    return 16'((pe << 10) | a);
  endfunction

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_read_en"}, 32'(read_en), 0);
    check_eq({tag, "_out_vld"}, 32'(out_vld), 0);
    check_eq({tag, "_read_addr"}, 32'(read_addr), 0);
    check_eq({tag, "_rd_rdy"}, 32'(read_data_rdy), 1);
  endtask

  task automatic cycle();
    logic req, dat, pop;
    logic [27:0] e;
    logic [15:0] a16;
    logic [11:0] i12;
    int lat;
    @(negedge clk);
    cyc++;
    interrupt = int_level;
    read_rdy  = (rdy_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
    case (ordy_mode)
      0:       out_rdy = 1'b0;
      1:       out_rdy = 1'b1;
      2:       out_rdy = (cyc >= start_cyc + 32);
      default: out_rdy = 1'($urandom_range(1));
    endcase
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      read_data_vld = 1'b1;
      read_data     = pend_q[0].word;
    end else begin
      read_data_vld = 1'b0;
      read_data     = $urandom;
    end
    #1;
    req = read_en & read_rdy;
    dat = read_data_vld & read_data_rdy;
    pop = out_vld & out_rdy;

    check_eq("busy", 32'(busy), 32'(sweep_on && cyc >= start_cyc + 2));
    check_eq("done", 32'(done), 32'(cyc == exp_done_cyc));
    check_eq("out_vld", 32'(out_vld), 32'(occ != 0));
    if (read_en) begin
      check_eq("credit", 32'((occ + n_req - n_recv) < DEPTH), 1);
      check_eq("overissue", 32'(n_req < act_no_m), 1);
    end
    if (prev_en && !prev_rdy) begin
      check_eq("hold_en", 32'(read_en), 1);
      check_eq("hold_addr", 32'(read_addr), 32'(prev_addr));
    end
    if (sweep_on && act_no_m > 0 && start_empty && cyc == start_cyc + 2)
      check_eq("start_lat", {15'd0, read_en, read_addr}, {15'd0, 1'b1, 16'h0000});

    if (req) begin
      check_eq("addr", 32'(read_addr), 32'(exp_addr(n_req)));
      a16 = (force_min && n_req == 0) ? 16'h8000 : 16'($urandom);
      i12 = 12'($urandom);
      lat = (rdy_mode == 0) ? 1 : int'($urandom_range(3, 1));
      pend_q.push_back('{due: cyc + lat, word: {4'($urandom), i12, a16}});
      n_req++;
    end
    if (dat && pend_q.size() > 0) begin
      exp_q.push_back(pend_q[0].word[27:0]);
      void'(pend_q.pop_front());
      occ++;
      n_recv++;
      if (n_recv == act_no_m) exp_done_cyc = cyc + 1;
    end
    if (pop) begin
      if (exp_q.size() == 0) begin
        check_eq("pop_unexpected", 32'(out_vld), 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_idx", 32'(out_idx), 32'(e[27:16]));
        check_eq("out_act", 32'(out_act), 32'(e[15:0]));
        if (e[15:0] == 16'h8000)
          check_eq("act_min_signed", {{16{out_act[15]}}, out_act}, 32'hFFFF8000);
        occ--;
      end
    end
    if (done) done_cnt++;
    if (cyc == exp_done_cyc) sweep_on = 0;
    prev_en   = read_en;
    prev_rdy  = read_rdy;
    prev_addr = read_addr;
  endtask

  task automatic clear_model();
    pend_q.delete();
    exp_q.delete();
    occ = 0; n_req = 0; n_recv = 0; act_no_m = 0;
    sweep_on = 0; exp_done_cyc = -1; prev_en = 0; prev_rdy = 0;
  endtask

  task automatic run_sweep(input int n, input int rmode, input int omode, input bit fmin,
                           input int ign_at, input int rst_at);
    act_no    = 12'(n);
    act_no_m  = n;
    n_req     = 0;
    n_recv    = 0;
    done_cnt  = 0;
    force_min = fmin;
    rdy_mode  = rmode;
    ordy_mode = omode;
    start_cyc   = cyc + 1;
    start_empty = (occ == 0);
    sweep_on    = 1;
    if (n == 0) exp_done_cyc = start_cyc + 2;
    int_level = 1;
    cycle();
    int_level = 0;
    for (int k = 0; k < 3000 && sweep_on; k++) begin
      int_level = (k == ign_at);
      if (rst_at >= 0 && n_req == rst_at) begin
        rst = 1'b0;
        #1;
        check_reset("rst_mid");
        clear_model();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        return;
      end
      cycle();
      if (omode == 2 && cyc == start_cyc + 30) check_eq("stall_reqs", 32'(n_req), DEPTH);
    end
    int_level = 0;
    check_eq("sweep_timeout", 32'(sweep_on), 0);
    check_eq("req_count", 32'(n_req), 32'(n));
    check_eq("done_count", 32'(done_cnt), 1);
  endtask

  task automatic drain();
    ordy_mode = 1;
    for (int k = 0; k < 200 && occ != 0; k++) cycle();
    cycle();
    check_eq("drain_empty", 32'(out_vld), 0);
  endtask

  initial begin
    rst = 1'b0; interrupt = 1'b0; act_no = '0; read_rdy = 1'b0;
    read_data_vld = 1'b0; read_data = '0; out_rdy = 1'b0;
    repeat (2) cycle();
    check_reset("rst0");
    rst = 1'b1;
    cycle();

    run_sweep(5, 0, 1, 0, -1, -1);   drain();
    run_sweep(66, 1, 3, 0, -1, -1);  drain();
    run_sweep(8, 0, 2, 1, -1, -1);   drain();
    run_sweep(0, 0, 1, 0, -1, -1);   drain();
    run_sweep(20, 1, 3, 0, 6, -1);   drain();
    run_sweep(10, 0, 1, 0, -1, 3);
    run_sweep(6, 1, 1, 0, -1, -1);   drain();
    for (int i = 0; i < 6; i++) run_sweep(int'($urandom_range(150, 1)), 1, 3, 0, -1, -1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/act_readout_seq.md
# act_readout_seq

Hardware read-out sequencer that sits directly downstream of `Accelerator` and consumes its read port. On the rising edge of `interrupt` it walks the output-activation address space in PE-major order (PE 0..63, then next activation slot), issuing read requests and collecting returned data. Collected data goes through a small FIFO and leaves as a ready/valid stream of (index, signed activation) pairs. This replaces the host-driven read-out loop with a self-timed block.

## Interface
Parameters:
- `ADDR_W`, 16, read address width (matches `AddrBus`)
- `RDATA_W`, 32, read data width (matches `ReadDataBus`)
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `interrupt`  in  1  accelerator done; rising edge starts a sweep
- `act_no`  in  12  activations to read; sampled on start
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse when the last activation has been pushed into the FIFO
- `read_en`  out  1  read request to accelerator
- `read_rdy`  in  1  accelerator accepts read request
- `read_addr`  out  ADDR_W  read address
- `read_data_rdy`  out  1  sequencer can accept read data
- `read_data_vld`  in  1  read data valid
- `read_data`  in  RDATA_W  [27:16] activation index, [15:0] signed activation
- `out_vld`  out  1  output stream valid
- `out_rdy`  in  1  output stream ready
- `out_idx`  out  12  activation index
- `out_act`  out  16  signed activation

## Operation
- States:
  - IDLE: on `interrupt` rising edge (registered previous value), latch `act_no` and clear counters. If `act_no`=0, go to FIN; else go to ISSUE.
  - ISSUE: issue requests until `issued`==`act_no`, then go to DRAIN.
  - DRAIN: wait until `received`==`act_no`, then go to FIN.
  - FIN: pulse `done` for one cycle, then go to IDLE.
- Address format:
  - `read_addr[15:10]`=pe_idx, `read_addr[5:0]`=act_addr, all other bits 0.
  - After each accepted request, pe_idx increments; at 63 it wraps to 0 and act_addr increments.
  - act_no=4095 ends at pe 62 / act 63. There is no act_addr overflow.
- Request transfer occurs when `read_en && read_rdy`.
  - `read_en` may be asserted only when credit>0, where credit = FIFO free slots − outstanding requests.
  - Once `read_en` is raised, it and `read_addr` are held stable until the transfer.
- Data transfer occurs when `read_data_vld && read_data_rdy`.
  - `read_data_rdy` = FIFO not full.
  - On each transfer the word is written into the FIFO and `received` increments.
  - Data arriving while in IDLE is dropped. `read_data_rdy` is 1 in IDLE.
- Output: `out_vld` = FIFO not empty. `out_idx`/`out_act` = FIFO head fields. The head pops when `out_vld && out_rdy`.
- Rising edges of `interrupt` while `busy` are ignored.
- `busy`=1 in ISSUE, DRAIN and FIN.
- The FIFO keeps draining after `done`. A new sweep may start while the FIFO is non-empty.

## Timing
- Reset values:
  - `busy`, `done`, `read_en`, `out_vld` = 0.
  - `read_addr` = 0.
  - `read_data_rdy` = 1.
  - All counters, the FIFO and the edge register are cleared.
- Assertion of `rst` mid-sweep aborts immediately to the reset state, with no `done` pulse.
- Start latency: `interrupt` rises at cycle N → `read_en`=1 with addr 0 at cycle N+2 (one cycle for edge detect, one for the state register).
- Back-to-back issue: with `read_rdy`=1 held and credit available, one request is accepted per cycle.
- Simultaneous FIFO push and pop when full is allowed. The count is unchanged; credit is computed from the registered count.
- FIFO read is first-word-fall-through: data pushed at cycle N gives `out_vld` at N+1.
- `done` is asserted the cycle after the final data transfer.

## Structure
- Shared package/header `global.vh`:
  - `AddrBus` and `ReadDataBus` widths
  - PE-index field [15:10], act-address field [5:0]
  - read-data field positions [27:16] and [15:0]
  - state encodings (IDLE=0, ISSUE=1, DRAIN=2, FIN=3)
- One sub-module: `sync_fifo`, a parameterised width/depth FIFO with FWFT output and full/empty/count outputs.

## Test plan
- act_no=5, `read_rdy`=1, data returned 1 cycle after each request, `out_rdy`=1 → addresses 0x0000, 0x0400, 0x0800, 0x0C00, 0x1000; 5 outputs in order; single `done` pulse.
- act_no=66 → request 64 has addr 0x0001, request 65 has addr 0x0401; 66 outputs; `done`.
- act_no=8, `out_rdy`=0 → exactly FIFO_DEPTH=4 requests issued, then `read_en` stays low; raising `out_rdy` completes all 8 and sends −32768 (0x8000) through as signed.
- `read_rdy` toggled low mid-request → `read_en`/`read_addr` held stable; no duplicate or skipped address.
- act_no=0 → `done` 2 cycles after the edge, no `read_en`.
- Second `interrupt` edge while busy → ignored.
- `rst` pulled low at request 3 → all outputs reach reset values; a new edge restarts from addr 0.
